prio_encoder_arb: RTL
=====================

Name: prio_encoder_arb

Overview:
- Parametrised, registered priority encoder/arbiter: successor to the 8-3 combinational priority encoder.
- Latches N active-low request lines into a pending register and encodes the winner (fixed-priority or round-robin) into a binary code.
- Offers the code on a valid/ready handshake and clears the served request on acceptance.
- Sits between interrupt/event sources and a single consumer (controller or display logic).

Parameters:
- N_CH, 8, number of request channels; legal range 2..64, non-power-of-2 allowed.
- CODE_W, $clog2(N_CH), code width; derived, never overridden.

Ports:
- iClk  input  1  clock; all state on rising edge.
- iRst_n  input  1  reset; asynchronous, active-low.
- iEI  input  1  enable, active-low; high = capture and new arbitration blocked.
- iReq  input  N_CH  request lines, active-low, level-sampled.
- iMask  input  N_CH  1 = channel excluded from arbitration (still latched).
- iMode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
- iReady  input  1  consumer accepts the offered code.
- oCode  output  CODE_W  granted channel index.
- oValid  output  1  oCode is offered.
- oPending  output  N_CH  pending register contents.
- oEO  output  1  high when iEI low and any unmasked pending bit is set.

Behaviour:
Reset (iRst_n low), asynchronous, effective immediately:
- oCode=0, oValid=0, oPending=0, rr pointer=0, state=IDLE.
- oEO=0, since it is derived combinationally from registers.
- Reset mid-offer drops oValid immediately; the offer is lost.

Capture, each clock:
- If iEI=0, pending[i] <= pending[i] | ~iReq[i].
- If iEI=1, no capture.
- A request held low re-pends every cycle.

Clear:
- On accept (oValid & iReady), pending[oCode] is cleared.
- If the same channel's iReq is low in the accept cycle, set wins and the bit stays 1.

Arbitration candidates: cand = pending & ~iMask.
- Fixed mode: winner = highest set index of cand.
- Round-robin mode: search upward from ptr, wrapping at N_CH-1 -> 0; winner = first set bit.

State machine:
- IDLE:
  - If iEI=0 and cand!=0: register the winner into oCode, set oValid=1, go to GRANT.
  - Otherwise oValid=0 and oCode holds its last value.
- GRANT:
  - oCode and oValid are held stable until iReady=1. Changes to iEI, iMask or iMode do not retract or alter the offer.
  - On iReady=1: clear pending[oCode], set ptr <= (oCode+1) mod N_CH, go to IDLE with oValid=0 next cycle.
  - ptr updates in both modes.

Latency and throughput:
- Request low at edge k -> pending set after k -> oValid=1 after edge k+1 (earliest).
- Maximum throughput is one grant per 2 cycles.

Mode changes: iMode and iMask changes take effect at the next IDLE evaluation.

oEO: combinational from pending, iMask and iEI; may remain 1 while GRANT is active if other channels are pending.

Pointer wrap: for non-power-of-2 N_CH, the ptr increment wraps explicitly at N_CH, never at 2^CODE_W.

Decomposition:
- Package prio_enc_pkg:
  - state typedef (ST_IDLE, ST_GRANT).
  - MODE_FIXED=1'b0, MODE_RR=1'b1.
  - function clog2 helper for CODE_W.
- Sub-module prio_pick_rot: combinational N_CH-bit picker with inputs cand, base, mode.
  - Output: index plus found flag.
  - Implements rotate -> highest/lowest-first scan -> un-rotate.
  - Instantiated once; all sequential logic stays in prio_encoder_arb.

Test Plan:
1. Reset: assert iRst_n=0 mid-GRANT with oValid=1 -> oValid, oCode, oPending drop to 0 without a clock edge; after release with iReq all 1s, oValid stays 0 and oEO=0.
2. Fixed priority, N_CH=8, iMode=0:
   - Stimulus: iReq=8'b0110_1111 for one cycle, iReady=1.
   - Response: oPending=8'h90; grants oCode=7 then oCode=4, each oValid one cycle, two cycles apart; final oPending=0, oEO=0.
3. Round-robin, iMode=1:
   - Stimulus: iReq=8'h00 for one cycle, iReady=1.
   - Response: oCode sequence 0,1,2,...,7, one grant every 2 cycles; ptr wraps to 0.
   - Repeat with N_CH=5: sequence 0..4, then ptr wraps to 0, never 5..7.
4. Mask and enable:
   - Pending 8'h81 with iMask=8'h80, fixed mode -> oCode=0 granted; bit 7 stays pending; oEO=0 afterwards.
   - iEI=1 with iReq=8'h00 -> oPending unchanged, no new offer.
5. Hold/back-pressure:
   - Offer oCode=3, iReady=0 for 5 cycles while iEI, iMask and iMode toggle -> oValid=1 and oCode=3 stable throughout.
   - iReady=1 -> pending[3] cleared next edge.
6. Simultaneous set/clear:
   - iReq[3] held low during the accept cycle of oCode=3 -> pending[3] remains 1.
   - Channel 3 is re-granted in fixed mode; in RR mode it is granted after the other pending channels.

Source files
------------

// File: rtl/prio_encoder_arb_pkg.sv
// Shared types and constants for the registered priority encoder/arbiter.
package prio_enc_pkg;

   typedef logic [0:0] stateT;
   localparam stateT ST_IDLE  = 1'b0;
   localparam stateT ST_GRANT = 1'b1;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Minimum 1 bit so a 2-channel build still has a code bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/prio_encoder_arb_pick.sv
// Combinational winner picker: rotate by base, scan, un-rotate.
module prio_pick_rot
   import prio_enc_pkg::*;
#(
   parameter  int unsigned N_CH   = 8,
   localparam int unsigned CODE_W = clog2(N_CH)
) (
   input  logic [N_CH-1:0]   iCand,
   input  logic [CODE_W-1:0] iBase,
   input  logic              iMode,
   output logic [CODE_W-1:0] oIdx,
   output logic              oFound
);

   function automatic int unsigned wrapIdx(input int unsigned v);
      return (v >= N_CH) ? v - N_CH : v;
   endfunction

   int unsigned     baseEff;
   int unsigned     hit;
   logic [N_CH-1:0] rot;

   // Fixed mode scans unrotated for the highest bit; RR scans rotated for the lowest.
   always_comb begin
      baseEff = (iMode == MODE_RR) ? 32'(iBase) : 32'd0;
      rot     = '0;
      hit     = 32'd0;
      for (int k = 0; k < N_CH; k++) begin
         rot[k] = iCand[CODE_W'(wrapIdx(baseEff + $unsigned(k)))];
      end
      for (int k = 0; k < N_CH; k++) begin
         if (iMode == MODE_RR) begin
            if (rot[N_CH-1-k]) hit = N_CH - 1 - $unsigned(k);
         end else if (rot[k]) begin
            hit = $unsigned(k);
         end
      end
      oFound = |rot;
      oIdx   = CODE_W'(wrapIdx(baseEff + hit));
   end

endmodule

// File: rtl/prio_encoder_arb.sv
// Registered N-channel priority encoder/arbiter with valid/ready code offer.
module prio_encoder_arb
   import prio_enc_pkg::*;
#(
   parameter  int unsigned N_CH   = 8,
   localparam int unsigned CODE_W = clog2(N_CH)
) (
   input  logic              iClk,
   input  logic              iRst_n,
   input  logic              iEI,
   input  logic [N_CH-1:0]   iReq,
   input  logic [N_CH-1:0]   iMask,
   input  logic              iMode,
   input  logic              iReady,
   output logic [CODE_W-1:0] oCode,
   output logic              oValid,
   output logic [N_CH-1:0]   oPending,
   output logic              oEO
);

   stateT             state, stateNxt;
   logic [CODE_W-1:0] ptr, ptrNxt, codeNxt, pickIdx;
   logic              validNxt, pickFound;
   logic [N_CH-1:0]   cand, clrVec, pendNxt;

   assign cand = oPending & ~iMask;
   assign oEO  = ~iEI & (|cand);

   prio_pick_rot #(.N_CH(N_CH)) uPick (
      .iCand  (cand),
      .iBase  (ptr),
      .iMode  (iMode),
      .oIdx   (pickIdx),
      .oFound (pickFound)
   );

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state    <= ST_IDLE;
         oCode    <= '0;
         oValid   <= 1'b0;
         oPending <= '0;
         ptr      <= '0;
      end else begin
         state    <= stateNxt;
         oCode    <= codeNxt;
         oValid   <= validNxt;
         oPending <= pendNxt;
         ptr      <= ptrNxt;
      end
   end

   // Offer is frozen in GRANT; capture is ORed after the clear so a held request wins.
   always_comb begin
      stateNxt = state;
      codeNxt  = oCode;
      validNxt = oValid;
      ptrNxt   = ptr;
      clrVec   = '0;
      case (state)
         ST_IDLE: begin
            validNxt = 1'b0;
            if (!iEI && pickFound) begin
               codeNxt  = pickIdx;
               validNxt = 1'b1;
               stateNxt = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (iReady) begin
               clrVec[oCode] = 1'b1;
               validNxt      = 1'b0;
               ptrNxt        = (32'(oCode) == N_CH - 1) ? '0 : oCode + CODE_W'(1);
               stateNxt      = ST_IDLE;
            end
         end
         default: stateNxt = ST_IDLE;
      endcase
      pendNxt = (oPending & ~clrVec) | (iEI ? '0 : ~iReq);
   end

endmodule
